// File: rtl/shift_n.sv
// shift_n: parametrised word shift register used as the pixel/line window
// buffer in front of the edge-detection kernels. DEPTH tap stages are followed
// by one registered output stage, every stage WIDTH bits wide. Words advance
// only when write_en is high; the pipeline is not time based.
//
// All state updates on the FALLING edge of clk. rst_n is asynchronous
// active-low and clears all contents. Its release takes effect at the next
// falling edge.
//
// Ports:
//   clk            clock, state updates on negedge
//   rst_n          asynchronous active-low reset
//   write_en       shift enable, one word accepted per falling edge
//   clear          synchronous flush, wins over write_en
//   data_in        word shifted into tap 1
//   data_out       word shifted out of tap DEPTH (registered)
//   data_out_valid data_out holds a written word, not a reset/clear value
//   taps           flattened tap bus, tap k (1 = newest) at [k*WIDTH-1:(k-1)*WIDTH]
//   tap_valid      bit k-1 set when tap k holds written data
//   fill_count     number of valid taps, saturates at DEPTH
//   full           fill_count == DEPTH
module shift_n #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write_en,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_out_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_valid,
  output logic [CW-1:0]          fill_count,
  output logic                   full
);

  localparam logic [DEPTH-1:0] VALID_LSB = DEPTH'(1);
  localparam logic [CW-1:0]    COUNT_MAX = CW'(DEPTH);

  // tap_q[0] is tap 1 (newest word), tap_q[DEPTH-1] is tap DEPTH.
  logic [WIDTH-1:0] tap_q [DEPTH];
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic [DEPTH-1:0] valid_q;
  logic [CW-1:0]    count_q;

  // Next valid vector on a write: shift the run of ones up by one and mark
  // tap 1 valid. The shift form also covers DEPTH=1, where it yields 1'b1.
  logic [DEPTH-1:0] valid_shifted;

  always_comb begin
    valid_shifted = (valid_q << 1) | VALID_LSB;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        tap_q[k] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
      valid_q     <= '0;
      count_q     <= '0;
    end else if (clear) begin
      // Flush wins over a simultaneous write. data_in is dropped.
      for (int k = 0; k < DEPTH; k++) begin
        tap_q[k] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
      valid_q     <= '0;
      count_q     <= '0;
    end else if (write_en) begin
      tap_q[0] <= data_in;
      for (int k = 1; k < DEPTH; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
      // The oldest tap falls into the output stage along with its valid flag.
      out_q       <= tap_q[DEPTH-1];
      out_valid_q <= valid_q[DEPTH-1];
      valid_q     <= valid_shifted;
      if (count_q != COUNT_MAX) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*WIDTH +: WIDTH] = tap_q[k];
  end

  assign data_out       = out_q;
  assign data_out_valid = out_valid_q;
  assign tap_valid      = valid_q;
  assign fill_count     = count_q;
  assign full           = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_shift_n.sv
// tb_shift_n: directed and randomised checks of shift_n in four configurations:
// 32x2 (default), 8x4 (deep), 8x3 (random against a queue model) and 8x1.
module tb_shift_n;

  logic clk;
  logic rst_n;

  logic        a_we, a_clr;
  logic [31:0] a_din, a_dout;
  logic        a_dov;
  logic [63:0] a_taps;
  logic [1:0]  a_tv, a_fill;
  logic        a_full;

  logic        b_we, b_clr;
  logic [7:0]  b_din, b_dout;
  logic        b_dov;
  logic [31:0] b_taps;
  logic [3:0]  b_tv;
  logic [2:0]  b_fill;
  logic        b_full;

  logic        c_we, c_clr;
  logic [7:0]  c_din, c_dout;
  logic        c_dov;
  logic [23:0] c_taps;
  logic [2:0]  c_tv;
  logic [1:0]  c_fill;
  logic        c_full;

  logic        d_we, d_clr;
  logic [7:0]  d_din, d_dout;
  logic        d_dov;
  logic [7:0]  d_taps;
  logic [0:0]  d_tv;
  logic [0:0]  d_fill;
  logic        d_full;

  int total;
  int bad;

  logic [7:0] model_q [$];

  shift_n #(.WIDTH(32), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .write_en(a_we), .clear(a_clr), .data_in(a_din),
    .data_out(a_dout), .data_out_valid(a_dov), .taps(a_taps), .tap_valid(a_tv),
    .fill_count(a_fill), .full(a_full)
  );

  shift_n #(.WIDTH(8), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .write_en(b_we), .clear(b_clr), .data_in(b_din),
    .data_out(b_dout), .data_out_valid(b_dov), .taps(b_taps), .tap_valid(b_tv),
    .fill_count(b_fill), .full(b_full)
  );

  shift_n #(.WIDTH(8), .DEPTH(3)) u_c (
    .clk(clk), .rst_n(rst_n), .write_en(c_we), .clear(c_clr), .data_in(c_din),
    .data_out(c_dout), .data_out_valid(c_dov), .taps(c_taps), .tap_valid(c_tv),
    .fill_count(c_fill), .full(c_full)
  );

  shift_n #(.WIDTH(8), .DEPTH(1)) u_d (
    .clk(clk), .rst_n(rst_n), .write_en(d_we), .clear(d_clr), .data_in(d_din),
    .data_out(d_dout), .data_out_valid(d_dov), .taps(d_taps), .tap_valid(d_tv),
    .fill_count(d_fill), .full(d_full)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idleAll();
    a_we = 1'b0; a_clr = 1'b0;
    b_we = 1'b0; b_clr = 1'b0;
    c_we = 1'b0; c_clr = 1'b0;
    d_we = 1'b0; d_clr = 1'b0;
  endtask

  // Drive one instance for one falling edge, then settle 2 time units past it.
  task automatic applyStimulus(input int which, input logic we, input logic clr, input logic [31:0] din);
    idleAll();
    case (which)
      0: begin a_we = we; a_clr = clr; a_din = din; end
      1: begin b_we = we; b_clr = clr; b_din = din[7:0]; end
      2: begin c_we = we; c_clr = clr; c_din = din[7:0]; end
      default: begin d_we = we; d_clr = clr; d_din = din[7:0]; end
    endcase
    @(negedge clk);
    #2;
  endtask

  // {taps, data_out, data_out_valid, tap_valid, fill_count, full} expected from the queue.
  function automatic logic [63:0] modelStatus();
    logic [23:0] et;
    logic [7:0]  edo;
    logic        edov;
    logic [2:0]  etv;
    logic [1:0]  efill;
    logic        efull;
    int          n;
    n = model_q.size();
    et = '0;
    etv = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < n) begin
        et[k*8 +: 8] = model_q[k];
        etv[k] = 1'b1;
      end
    end
    edo   = (n > 3) ? model_q[3] : 8'h00;
    edov  = (n > 3);
    efill = (n >= 3) ? 2'd3 : 2'(n);
    efull = (n >= 3);
    return 64'({et, edo, edov, etv, efill, efull});
  endfunction

  function automatic logic [63:0] dutStatusC();
    return 64'({c_taps, c_dout, c_dov, c_tv, c_fill, c_full});
  endfunction

  logic [3:0] b_tv_tab   [6] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF};
  logic [2:0] b_fill_tab [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
  logic [7:0] b_do_tab   [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
  logic       b_dov_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    logic       we;
    logic       clr;
    logic [7:0] rd;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a_din = '0; b_din = '0; c_din = '0; d_din = '0;
    idleAll();

    // Reset state while rst_n is held low.
    #12;
    checkOutput("rst_a_taps", a_taps, 64'h0);
    checkOutput("rst_a_flags", 64'({a_dout, a_dov, a_tv, a_fill, a_full}), 64'h0);
    checkOutput("rst_b_flags", 64'({b_taps, b_dout, b_dov, b_tv, b_fill, b_full}), 64'h0);
    rst_n = 1'b1;

    // Put A mid-stream, then reset it between edges.
    applyStimulus(0, 1'b1, 1'b0, 32'hAAAA_AAAA);
    applyStimulus(0, 1'b1, 1'b0, 32'hBBBB_BBBB);
    checkOutput("pre_rst_a_taps", a_taps, 64'hAAAA_AAAA_BBBB_BBBB);
    checkOutput("pre_rst_a_full", 64'({a_fill, a_full}), 64'({2'd2, 1'b1}));
    idleAll();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_a_taps", a_taps, 64'h0);
    checkOutput("async_rst_a_flags", 64'({a_dout, a_dov, a_tv, a_fill, a_full}), 64'h0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b0, 1'b0, 32'hDEAD_0000 + 32'(i));
      checkOutput("post_rst_idle", 64'({a_taps[31:0], a_dout, a_dov, a_tv, a_fill, a_full}) ^ 64'(a_taps[63:32]), 64'h0);
    end

    // Fill / shift, DEPTH=2.
    applyStimulus(0, 1'b1, 1'b0, 32'h11);
    checkOutput("w1_taps", a_taps, 64'h0000_0000_0000_0011);
    checkOutput("w1_flags", 64'({a_dov, a_tv, a_fill, a_full}), 64'({1'b0, 2'b01, 2'd1, 1'b0}));
    applyStimulus(0, 1'b1, 1'b0, 32'h22);
    checkOutput("w2_taps", a_taps, 64'h0000_0011_0000_0022);
    checkOutput("w2_flags", 64'({a_dov, a_tv, a_fill, a_full}), 64'({1'b0, 2'b11, 2'd2, 1'b1}));
    applyStimulus(0, 1'b1, 1'b0, 32'h33);
    checkOutput("w3_taps", a_taps, 64'h0000_0022_0000_0033);
    checkOutput("w3_dout", 64'(a_dout), 64'h11);
    checkOutput("w3_flags", 64'({a_dov, a_tv, a_fill, a_full}), 64'({1'b1, 2'b11, 2'd2, 1'b1}));

    // Hold with data_in toggling.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, 1'b0, $urandom);
      checkOutput("hold_taps", a_taps, 64'h0000_0022_0000_0033);
      checkOutput("hold_out", 64'({a_dout, a_dov, a_tv, a_fill, a_full}), 64'({32'h11, 1'b1, 2'b11, 2'd2, 1'b1}));
    end

    // Clear has priority over a simultaneous write.
    applyStimulus(0, 1'b1, 1'b1, 32'h44);
    checkOutput("clr_taps", a_taps, 64'h0);
    checkOutput("clr_flags", 64'({a_dout, a_dov, a_tv, a_fill, a_full}), 64'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h55);
    checkOutput("after_clr_taps", a_taps, 64'h0000_0000_0000_0055);
    checkOutput("after_clr_flags", 64'({a_dout, a_dov, a_tv, a_fill, a_full}), 64'({32'h0, 1'b0, 2'b01, 2'd1, 1'b0}));

    // Deep config, WIDTH=8, DEPTH=4.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1'b1, 1'b0, 32'(i + 1));
      checkOutput("deep_tv", 64'(b_tv), 64'(b_tv_tab[i]));
      checkOutput("deep_fill", 64'({b_fill, b_full}), 64'({b_fill_tab[i], b_fill_tab[i] == 3'd4}));
      checkOutput("deep_out", 64'({b_dout, b_dov}), 64'({b_do_tab[i], b_dov_tab[i]}));
    end
    checkOutput("deep_taps", 64'(b_taps), 64'h0304_0506);

    // DEPTH=1: output becomes valid on the second write.
    applyStimulus(3, 1'b1, 1'b0, 32'hA1);
    checkOutput("d1_w1", 64'({d_taps, d_dout, d_dov, d_tv, d_fill, d_full}), 64'({8'hA1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}));
    applyStimulus(3, 1'b1, 1'b0, 32'hA2);
    checkOutput("d1_w2", 64'({d_taps, d_dout, d_dov, d_tv, d_fill, d_full}), 64'({8'hA2, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b1}));

    // Random scoreboard, DEPTH=3.
    applyStimulus(2, 1'b0, 1'b1, 32'h0);
    model_q.delete();
    checkOutput("rand_start", dutStatusC(), modelStatus());
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        idleAll();
        #1;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        checkOutput("rand_async_rst", dutStatusC(), modelStatus());
        rst_n = 1'b1;
      end
      we  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 19) == 0);
      rd  = 8'($urandom);
      if (we && !clr) begin
        applyStimulus(2, we, clr, {24'h0, rd});
      end else begin
        applyStimulus(2, we, clr, 'x);
      end
      if (clr) begin
        model_q.delete();
      end else if (we) begin
        model_q.push_front(rd);
        if (model_q.size() > 4) begin
          void'(model_q.pop_back());
        end
      end
      checkOutput("rand_status", dutStatusC(), modelStatus());
      checkOutput("rand_contig", 64'((c_tv & (c_tv + 3'd1)) == 3'd0), 64'h1);
      checkOutput("rand_popcount", 64'($countones(c_tv)), 64'(c_fill));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
